// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache in front of one memory port; one access outstanding at a time.
// Strobe one cycle after request, ready passed through combinationally on mem_ready; requests are held by the caches until their ready.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ready,
  output logic [DATA_W-1:0] icache_rdata,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic              dcache_ready,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_d, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              i_req, d_req, pick_d;

  assign i_req  = icache_read;
  assign d_req  = dcache_read | dcache_write;
  // D-cache wins a tie unless it was the last one served
  assign pick_d = d_req & (~i_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read;
    mem_write_d  = mem_write;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
          mem_addr_d   = dcache_addr;
          mem_wdata_d  = dcache_wdata;
          mem_write_d  = dcache_write;
          mem_read_d   = dcache_read & ~dcache_write;
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
          mem_addr_d   = icache_addr;
          mem_read_d   = 1'b1;
          mem_write_d  = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read     <= mem_read_d;
      mem_write    <= mem_write_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
    end
  end

  assign icache_ready = (state_q == SERVE_I) & mem_ready;
  assign dcache_ready = (state_q == SERVE_D) & mem_ready;
  assign icache_rdata = icache_ready ? mem_rdata : '0;
  assign dcache_rdata = dcache_ready ? mem_rdata : '0;

endmodule
